nn_layer_sequencer: RTL

Control FSM that sequences the shared fixed-point MAC datapath of the nn block through a multi-layer fully-connected inference pass. It holds per-layer sizes and steps neuron and input counters. It drives weight/bias/activation addresses and the MAC, writeback and ReLU controls, and ping-pongs two activation banks between layers. A host starts a pass with a start/ready handshake and receives a one-cycle done pulse.

---
 rtl/nn_layer_sequencer.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/nn_layer_sequencer.sv
// Sequences the shared MAC datapath through a multi-layer fully-connected pass.
// Outputs decode directly from state and counters; two activation banks alternate between layers.
module nn_layer_sequencer #(
  parameter int NUM_LAYERS = 3,
  parameter int MAX_N      = 16,
  parameter int CW         = $clog2(MAX_N + 1),
  parameter int WAW        = 10,
  parameter int BAW        = 6,
  parameter int AAW        = $clog2(MAX_N),
  localparam int LW        = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           abort,
  output logic           ready,
  output logic           done,
  output logic           busy,
  input  logic           cfg_we,
  input  logic [LW-1:0]  cfg_layer,
  input  logic [CW-1:0]  cfg_in_cnt,
  input  logic [CW-1:0]  cfg_out_cnt,
  output logic [WAW-1:0] w_addr,
  output logic [BAW-1:0] b_addr,
  output logic [AAW-1:0] act_raddr,
  output logic [AAW-1:0] act_waddr,
  output logic           rd_bank,
  output logic           mac_load,
  output logic           mac_en,
  output logic           act_we,
  output logic           relu_en,
  output logic [LW-1:0]  layer
);

  typedef enum logic [2:0] {
    S_IDLE, S_BIAS, S_MAC, S_WB, S_NEXT, S_DONE
  } state_t;

  localparam logic [LW-1:0] LAST_LAYER = LW'(NUM_LAYERS - 1);

  state_t         state;
  logic [CW-1:0]  in_cfg  [NUM_LAYERS];
  logic [CW-1:0]  out_cfg [NUM_LAYERS];
  logic [CW-1:0]  k;
  logic [CW-1:0]  n;
  logic [LW-1:0]  layer_q;
  logic [WAW-1:0] w_ptr;
  logic [BAW-1:0] b_ptr;
  logic           bank_q;
  logic [CW-1:0]  cur_in;
  logic [CW-1:0]  cur_out;
  logic           cfg_ok;

  function automatic logic [CW-1:0] clamp_cnt(input logic [CW-1:0] c);
    if (c == '0)
      return CW'(1);
    else if (c > CW'(MAX_N))
      return CW'(MAX_N);
    else
      return c;
  endfunction

  assign cur_in  = in_cfg[layer_q];
  assign cur_out = out_cfg[layer_q];
  assign cfg_ok  = (32'(cfg_layer) < NUM_LAYERS);

  // Weights and biases are laid out contiguously in traversal order, so running
  // pointers replace the base + n*in_cnt + k products.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      k       <= '0;
      n       <= '0;
      layer_q <= '0;
      w_ptr   <= '0;
      b_ptr   <= '0;
      bank_q  <= 1'b0;
      for (int i = 0; i < NUM_LAYERS; i++) begin
        in_cfg[i]  <= CW'(1);
        out_cfg[i] <= CW'(1);
      end
    end else begin
      if (state == S_IDLE && cfg_we && cfg_ok) begin
        in_cfg[cfg_layer]  <= clamp_cnt(cfg_in_cnt);
        out_cfg[cfg_layer] <= clamp_cnt(cfg_out_cnt);
      end
      if (abort && state != S_IDLE) begin
        state <= S_IDLE;
        k     <= '0;
        n     <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              layer_q <= '0;
              n       <= '0;
              k       <= '0;
              w_ptr   <= '0;
              b_ptr   <= '0;
              state   <= S_BIAS;
            end
          end
          S_BIAS: begin
            k     <= '0;
            state <= S_MAC;
          end
          S_MAC: begin
            w_ptr <= w_ptr + WAW'(1);
            if (k == cur_in - CW'(1)) begin
              k     <= '0;
              state <= S_WB;
            end else begin
              k <= k + CW'(1);
            end
          end
          S_WB: begin
            b_ptr <= b_ptr + BAW'(1);
            if (n == cur_out - CW'(1)) begin
              state <= S_NEXT;
            end else begin
              n     <= n + CW'(1);
              state <= S_BIAS;
            end
          end
          S_NEXT: begin
            bank_q <= ~bank_q;
            if (layer_q == LAST_LAYER) begin
              state <= S_DONE;
            end else begin
              layer_q <= layer_q + LW'(1);
              n       <= '0;
              state   <= S_BIAS;
            end
          end
          S_DONE: state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign ready     = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign mac_load  = (state == S_BIAS);
  assign mac_en    = (state == S_MAC);
  assign act_we    = (state == S_WB);
  assign relu_en   = (state == S_WB) && (layer_q != LAST_LAYER);
  assign w_addr    = (state == S_MAC)  ? w_ptr : '0;
  assign b_addr    = (state == S_BIAS) ? b_ptr : '0;
  assign act_raddr = (state == S_MAC)  ? k[AAW-1:0] : '0;
  assign act_waddr = (state == S_WB)   ? n[AAW-1:0] : '0;
  assign rd_bank   = bank_q;
  assign layer     = layer_q;

endmodule
